// File: rtl/data_memory_responder_if.sv
// Cache miss/write-back port between the data cache (master) and the backing memory (slave).
interface data_memory_responder_if;
  logic        MemReq;
  logic        MemWrite2Memory;
  logic [31:0] MissAddr;
  logic [31:0] Data2Memory;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemBusy;
  logic        AddrErr;

  modport master (
    output MemReq, MemWrite2Memory, MissAddr, Data2Memory,
    input  ReadData, MemReady, MemBusy, AddrErr
  );

  modport slave (
    input  MemReq, MemWrite2Memory, MissAddr, Data2Memory,
    output ReadData, MemReady, MemBusy, AddrErr
  );
endinterface

// File: rtl/data_memory_responder.sv
// Single-outstanding memory responder: word RAM behind the data cache miss port,
// answering each accepted request with a one-cycle MemReady after LATENCY cycles.
module data_memory_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter     INIT_FILE  = ""
) (
  input  logic                   CLK,
  input  logic                   Reset,
  data_memory_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  we_q, err_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [31:0]           mem [DEPTH];

  logic                  req_err, accept, enter_resp;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_we, acc_err;
  logic [31:0]           acc_wdata;

  assign req_err = (bus.MissAddr[1:0] != 2'b00) || (|bus.MissAddr[31:DEPTH_LOG2+2]);
  assign accept  = (state == IDLE) && bus.MemReq;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (bus.MemReq) begin
        if (LATENCY == 1) state_nxt = RESP;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(LATENCY - 2);
        end
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the RAM access happens on the acceptance edge itself,
  // so the request fields come straight from the bus instead of the latches.
  assign enter_resp = (state_nxt == RESP);
  assign acc_idx    = (state == IDLE) ? bus.MissAddr[DEPTH_LOG2+1:2] : idx_q;
  assign acc_we     = (state == IDLE) ? bus.MemWrite2Memory          : we_q;
  assign acc_err    = (state == IDLE) ? req_err                      : err_q;
  assign acc_wdata  = (state == IDLE) ? bus.Data2Memory              : wdata_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q   <= bus.MissAddr[DEPTH_LOG2+1:2];
        we_q    <= bus.MemWrite2Memory;
        err_q   <= req_err;
        wdata_q <= bus.Data2Memory;
      end
      if (enter_resp && !acc_we) rdata_q <= acc_err ? 32'h0 : mem[acc_idx];
    end
  end

  // RAM has no reset; the Reset term keeps a write from landing while reset is held.
  always_ff @(posedge CLK) begin
    if (Reset && enter_resp && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = (state == RESP);
  assign bus.MemBusy  = (state != IDLE);
  assign bus.AddrErr  = (state == RESP) && err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=4 instance for most scenarios,
// LATENCY=1 instance for the single-cycle turnaround case.
module tb_data_memory_responder;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  data_memory_responder_if b ();
  data_memory_responder_if b1 ();

  data_memory_responder #(.DEPTH_LOG2(10), .LATENCY(4), .INIT_FILE("")) dut (
    .CLK(CLK), .Reset(Reset), .bus(b)
  );
  data_memory_responder #(.DEPTH_LOG2(10), .LATENCY(1), .INIT_FILE("")) dut1 (
    .CLK(CLK), .Reset(Reset), .bus(b1)
  );

  always #5 CLK = ~CLK;

  // Issue one request on the LATENCY=4 port and watch 8 cycles after acceptance.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err,
                     output logic [15:0] rdy_m, output logic [15:0] busy_m);
    @(negedge CLK);
    b.MemReq = 1'b1; b.MemWrite2Memory = we; b.MissAddr = addr; b.Data2Memory = wd;
    @(posedge CLK);
    #1 b.MemReq = 1'b0;
    rd = '0; err = 1'b0; rdy_m = '0; busy_m = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      busy_m[c] = b.MemBusy;
      rdy_m[c]  = b.MemReady;
      if (b.MemReady) begin rd = b.ReadData; err = b.AddrErr; end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++; if ({b.MemReady, b.MemBusy, b.AddrErr} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=000", {b.MemReady, b.MemBusy, b.AddrErr}); end
    tests++; if (b.ReadData !== 32'h0) begin
      fails++; $display("FAIL reset_rdata got=%h exp=00000000", b.ReadData); end
    tests++; if ({b1.MemReady, b1.MemBusy, b1.AddrErr, b1.ReadData} !== 35'h0) begin
      fails++; $display("FAIL reset_lat1 got=%h exp=0", {b1.MemReady, b1.MemBusy, b1.AddrErr, b1.ReadData}); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; logic [15:0] rm, bm;
    txn(1'b1, 32'h40, 32'hDEADBEEF, rd, err, rm, bm);
    tests++; if (rm !== 16'h0010) begin fails++; $display("FAIL wr_ready_mask got=%h exp=0010", rm); end
    tests++; if (bm !== 16'h001E) begin fails++; $display("FAIL wr_busy_mask got=%h exp=001e", bm); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL wr_err got=%b exp=0", err); end
    tests++; if (b.ReadData !== 32'h0) begin fails++; $display("FAIL wr_keeps_rdata got=%h exp=00000000", b.ReadData); end
    txn(1'b0, 32'h40, 32'h0, rd, err, rm, bm);
    tests++; if (rm !== 16'h0010) begin fails++; $display("FAIL rd_ready_mask got=%h exp=0010", rm); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rd_err got=%b exp=0", err); end
  endtask

  task automatic test_addr_err();
    logic [31:0] rd; logic err; logic [15:0] rm, bm;
    txn(1'b1, 32'h0, 32'h5A5A0001, rd, err, rm, bm);
    txn(1'b0, 32'h42, 32'h0, rd, err, rm, bm);
    tests++; if (rm !== 16'h0010) begin fails++; $display("FAIL mis_ready got=%h exp=0010", rm); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_err got=%b exp=1", err); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL mis_rdata got=%h exp=00000000", rd); end
    txn(1'b1, 32'h1000, 32'h00000077, rd, err, rm, bm);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL oor_err got=%b exp=1", err); end
    txn(1'b0, 32'h0, 32'h0, rd, err, rm, bm);
    tests++; if (rd !== 32'h5A5A0001) begin fails++; $display("FAIL oor_no_alias got=%h exp=5a5a0001", rd); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL oor_read_err got=%b exp=0", err); end
  endtask

  task automatic test_input_latch();
    logic [31:0] rd; logic err; logic [15:0] rm, bm;
    txn(1'b1, 32'h80, 32'h0BADF00D, rd, err, rm, bm);
    @(negedge CLK);
    b.MemReq = 1'b1; b.MemWrite2Memory = 1'b1; b.MissAddr = 32'h10; b.Data2Memory = 32'h1234;
    @(posedge CLK);
    #1 b.MemReq = 1'b0;
    @(negedge CLK);
    b.MissAddr = 32'h80; b.Data2Memory = 32'hFFFF;
    repeat (7) @(negedge CLK);
    txn(1'b0, 32'h10, 32'h0, rd, err, rm, bm);
    tests++; if (rd !== 32'h1234) begin fails++; $display("FAIL latch_target got=%h exp=00001234", rd); end
    txn(1'b0, 32'h80, 32'h0, rd, err, rm, bm);
    tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL latch_other got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic err; logic [15:0] rm, bm;
    int rdy_seen;
    txn(1'b1, 32'h20, 32'h0, rd, err, rm, bm);
    @(negedge CLK);
    b.MemReq = 1'b1; b.MemWrite2Memory = 1'b1; b.MissAddr = 32'h20; b.Data2Memory = 32'hAA;
    @(posedge CLK);
    #1 b.MemReq = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 Reset = 1'b0;
    #1;
    tests++; if ({b.MemReady, b.MemBusy, b.AddrErr} !== 3'b000) begin
      fails++; $display("FAIL abort_ctrl got=%b exp=000", {b.MemReady, b.MemBusy, b.AddrErr}); end
    tests++; if (b.ReadData !== 32'h0) begin fails++; $display("FAIL abort_rdata got=%h exp=00000000", b.ReadData); end
    rdy_seen = 0;
    repeat (2) begin @(negedge CLK); if (b.MemReady) rdy_seen++; end
    Reset = 1'b1;
    repeat (6) begin @(negedge CLK); if (b.MemReady) rdy_seen++; end
    tests++; if (rdy_seen !== 0) begin fails++; $display("FAIL abort_no_ready got=%0d exp=0", rdy_seen); end
    txn(1'b0, 32'h20, 32'h0, rd, err, rm, bm);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL abort_no_commit got=%h exp=00000000", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; logic [15:0] rm, bm;
    logic [20:0] mask;
    logic [31:0] seen [4];
    int k;
    txn(1'b1, 32'h4, 32'hC0FFEE04, rd, err, rm, bm);
    mask = '0; k = 0;
    for (int i = 0; i < 4; i++) seen[i] = '0;
    @(negedge CLK);
    b.MemReq = 1'b1; b.MemWrite2Memory = 1'b0; b.MissAddr = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (b.MemReady) begin
        mask[c] = 1'b1;
        if (k < 4) seen[k] = b.ReadData;
        k++;
        b.MissAddr = (b.MissAddr == 32'h0) ? 32'h4 : 32'h0;
      end
      if (c == 20) b.MemReq = 1'b0;
    end
    tests++; if (mask !== 21'h084210) begin fails++; $display("FAIL b2b_spacing got=%h exp=084210", mask); end
    tests++; if (seen[0] !== 32'h5A5A0001 || seen[2] !== 32'h5A5A0001) begin
      fails++; $display("FAIL b2b_even got=%h/%h exp=5a5a0001", seen[0], seen[2]); end
    tests++; if (seen[1] !== 32'hC0FFEE04 || seen[3] !== 32'hC0FFEE04) begin
      fails++; $display("FAIL b2b_odd got=%h/%h exp=c0ffee04", seen[1], seen[3]); end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_latency1();
    @(negedge CLK);
    b1.MemReq = 1'b1; b1.MemWrite2Memory = 1'b1; b1.MissAddr = 32'h8; b1.Data2Memory = 32'h88;
    @(posedge CLK);
    #1 b1.MemReq = 1'b0;
    @(negedge CLK);
    tests++; if (b1.MemReady !== 1'b1) begin fails++; $display("FAIL l1_wr_ready got=%b exp=1", b1.MemReady); end
    @(negedge CLK);
    b1.MemReq = 1'b1; b1.MemWrite2Memory = 1'b0; b1.MissAddr = 32'h8;
    @(posedge CLK);
    #1 b1.MemReq = 1'b0;
    @(negedge CLK);
    tests++; if ({b1.MemReady, b1.MemBusy, b1.AddrErr} !== 3'b110) begin
      fails++; $display("FAIL l1_rd_ctrl got=%b exp=110", {b1.MemReady, b1.MemBusy, b1.AddrErr}); end
    tests++; if (b1.ReadData !== 32'h88) begin fails++; $display("FAIL l1_rd_data got=%h exp=00000088", b1.ReadData); end
    @(negedge CLK);
    tests++; if (b1.MemReady !== 1'b0) begin fails++; $display("FAIL l1_single_pulse got=%b exp=0", b1.MemReady); end
  endtask

  initial begin
    b.MemReq = 1'b0; b.MemWrite2Memory = 1'b0; b.MissAddr = '0; b.Data2Memory = '0;
    b1.MemReq = 1'b0; b1.MemWrite2Memory = 1'b0; b1.MissAddr = '0; b1.Data2Memory = '0;
    repeat (2) @(negedge CLK);
    test_reset();
    @(negedge CLK);
    Reset = 1'b1;
    test_write_read();
    test_addr_err();
    test_input_latch();
    test_reset_abort();
    test_back_to_back();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
